// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing controller: phase encoding,
// 1080p default timing and the layout of a packed timing set.
package video_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phaseState_e;

    localparam int unsigned defHActive = 1920;
    localparam int unsigned defHFront  = 88;
    localparam int unsigned defHSync   = 44;
    localparam int unsigned defHBack   = 148;
    localparam int unsigned defVActive = 1080;
    localparam int unsigned defVFront  = 4;
    localparam int unsigned defVSync   = 5;
    localparam int unsigned defVBack   = 36;

    // Field slots inside a packed timing set
    localparam int unsigned numFields = 8;
    localparam int unsigned idxHActive = 0;
    localparam int unsigned idxHFront  = 1;
    localparam int unsigned idxHSync   = 2;
    localparam int unsigned idxHBack   = 3;
    localparam int unsigned idxVActive = 4;
    localparam int unsigned idxVFront  = 5;
    localparam int unsigned idxVSync   = 6;
    localparam int unsigned idxVBack   = 7;

    function automatic phaseState_e nextPhase(input phaseState_e cur);
        phaseState_e nxt;
        nxt = ACTIVE;
        case (cur)
            ACTIVE: nxt = FRONT;
            FRONT:  nxt = SYNC;
            SYNC:   nxt = BACK;
            BACK:   nxt = ACTIVE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/timing_phase_fsm.sv
// One timing axis: walks ACTIVE -> FRONT -> SYNC -> BACK, each phase lasting
// its programmed length (0 behaves as 1), advancing once per step.
module timing_phase_fsm
    import video_timing_pkg::*;
#(
    parameter int unsigned busWidth = 12
) (
    input  logic                pixelClk,
    input  logic                reset,
    input  logic                step,
    input  logic                clear,
    input  logic [busWidth-1:0] activeLen,
    input  logic [busWidth-1:0] frontLen,
    input  logic [busWidth-1:0] syncLen,
    input  logic [busWidth-1:0] backLen,
    output phaseState_e         state,
    output logic [busWidth-1:0] count,
    output logic                wrap_c
);

    logic [busWidth-1:0] phaseLen;
    logic                phaseEnd;

    always_comb begin
        phaseLen = activeLen;
        case (state)
            ACTIVE: phaseLen = activeLen;
            FRONT:  phaseLen = frontLen;
            SYNC:   phaseLen = syncLen;
            BACK:   phaseLen = backLen;
        endcase
    end

    // Lengths of 0 and 1 both end the phase after a single step
    assign phaseEnd = (phaseLen <= busWidth'(1)) || (count == phaseLen - busWidth'(1));
    assign wrap_c   = step && !clear && (state == BACK) && phaseEnd;

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            state <= ACTIVE;
            count <= '0;
        end else if (clear) begin
            state <= ACTIVE;
            count <= '0;
        end else if (step) begin
            if (phaseEnd) begin
                state <= nextPhase(state);
                count <= '0;
            end else begin
                count <= count + busWidth'(1);
            end
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Programmable raster timing generator with frame-synchronous reconfiguration.
// The phase FSMs run one cycle ahead of the registered outputs they drive.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int unsigned busWidth   = 12,
    parameter int unsigned hActiveDef = defHActive,
    parameter int unsigned hFrontDef  = defHFront,
    parameter int unsigned hSyncDef   = defHSync,
    parameter int unsigned hBackDef   = defHBack,
    parameter int unsigned vActiveDef = defVActive,
    parameter int unsigned vFrontDef  = defVFront,
    parameter int unsigned vSyncDef   = defVSync,
    parameter int unsigned vBackDef   = defVBack
) (
    input  logic                pixelClk,
    input  logic                reset,
    input  logic                enable,
    input  logic [busWidth-1:0] hActive,
    input  logic [busWidth-1:0] hFront,
    input  logic [busWidth-1:0] hSync,
    input  logic [busWidth-1:0] hBack,
    input  logic [busWidth-1:0] vActive,
    input  logic [busWidth-1:0] vFront,
    input  logic [busWidth-1:0] vSync,
    input  logic [busWidth-1:0] vBack,
    input  logic                cfgValid,
    output logic                cfgApplied,
    output logic                hSyncPulse,
    output logic                vSyncPulse,
    output logic                dataEnable,
    output logic [busWidth-1:0] xPos,
    output logic [busWidth-1:0] yPos,
    output logic                lineStart,
    output logic                frameStart
);

    typedef logic [numFields-1:0][busWidth-1:0] timingSet_t;

    localparam timingSet_t defaultSet = {
        busWidth'(vBackDef), busWidth'(vSyncDef), busWidth'(vFrontDef), busWidth'(vActiveDef),
        busWidth'(hBackDef), busWidth'(hSyncDef), busWidth'(hFrontDef), busWidth'(hActiveDef)
    };

    timingSet_t          requestSet;
    timingSet_t          activeSet;
    timingSet_t          pendingSet;
    timingSet_t          useSet;
    logic                pendingValid;
    logic                atFrameStart;
    logic                applyNow;

    phaseState_e         hState;
    phaseState_e         vState;
    logic [busWidth-1:0] hCount;
    logic [busWidth-1:0] vCount;
    logic                hWrap;
    logic                vWrap;

    logic                activeRegion;
    logic                lineFirst;
    logic                frameFirst;

    assign requestSet = {vBack, vSync, vFront, vActive, hBack, hSync, hFront, hActive};

    // A pending set takes over as the FSMs sit on the first pixel of a frame;
    // a capture landing on that same cycle defers everything to the next frame.
    assign applyNow = enable && pendingValid && atFrameStart && !cfgValid;
    assign useSet   = applyNow ? pendingSet : activeSet;

    timing_phase_fsm #(.busWidth(busWidth)) hAxis (
        .pixelClk  (pixelClk),
        .reset     (reset),
        .step      (enable),
        .clear     (!enable),
        .activeLen (useSet[idxHActive]),
        .frontLen  (useSet[idxHFront]),
        .syncLen   (useSet[idxHSync]),
        .backLen   (useSet[idxHBack]),
        .state     (hState),
        .count     (hCount),
        .wrap_c    (hWrap)
    );

    timing_phase_fsm #(.busWidth(busWidth)) vAxis (
        .pixelClk  (pixelClk),
        .reset     (reset),
        .step      (hWrap),
        .clear     (!enable),
        .activeLen (useSet[idxVActive]),
        .frontLen  (useSet[idxVFront]),
        .syncLen   (useSet[idxVSync]),
        .backLen   (useSet[idxVBack]),
        .state     (vState),
        .count     (vCount),
        .wrap_c    (vWrap)
    );

    assign activeRegion = enable && (hState == ACTIVE) && (vState == ACTIVE);
    assign lineFirst    = enable && (hState == ACTIVE) && (hCount == '0);
    assign frameFirst   = lineFirst && (vState == ACTIVE) && (vCount == '0);

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            activeSet    <= defaultSet;
            pendingSet   <= defaultSet;
            pendingValid <= 1'b0;
            atFrameStart <= 1'b1;
            cfgApplied   <= 1'b0;
            hSyncPulse   <= 1'b0;
            vSyncPulse   <= 1'b0;
            dataEnable   <= 1'b0;
            xPos         <= '0;
            yPos         <= '0;
            lineStart    <= 1'b0;
            frameStart   <= 1'b0;
        end else begin
            if (cfgValid) begin
                pendingSet   <= requestSet;
                pendingValid <= 1'b1;
            end else if (applyNow) begin
                pendingValid <= 1'b0;
            end
            if (applyNow) begin
                activeSet <= pendingSet;
            end
            atFrameStart <= !enable || vWrap;
            cfgApplied   <= applyNow;
            hSyncPulse   <= enable && (hState == SYNC);
            vSyncPulse   <= enable && (vState == SYNC);
            dataEnable   <= activeRegion;
            xPos         <= activeRegion ? hCount : '0;
            yPos         <= activeRegion ? vCount : '0;
            lineStart    <= lineFirst;
            frameStart   <= frameFirst;
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed and randomized checks of video_timing_ctrl against a frame-position
// reference model derived from the timing arithmetic.
module tb_video_timing_ctrl;

    localparam int unsigned W = 12;

    logic          pixelClk = 1'b0;
    logic          reset    = 1'b1;
    logic          enable   = 1'b0;
    logic          cfgValid = 1'b0;
    int            cfgIn [8];
    logic [W-1:0]  hActive, hFront, hSync, hBack, vActive, vFront, vSync, vBack;
    logic          cfgApplied, hSyncPulse, vSyncPulse, dataEnable, lineStart, frameStart;
    logic [W-1:0]  xPos, yPos;
    logic [29:0]   obsVec;

    // Reference model state
    int            act [8];
    int            pend [8];
    bit            pf;
    int            t;
    logic [29:0]   expVec;

    int            nChecks = 0;
    int            nPass   = 0;

    // Window monitors
    int            rel, deCnt, vsCnt, vsFirst, fsCnt, fsLast, fsGap, lsLast, lsGap, appCnt;
    logic [7:0]    hsPat;

    assign hActive = W'(cfgIn[0]);
    assign hFront  = W'(cfgIn[1]);
    assign hSync   = W'(cfgIn[2]);
    assign hBack   = W'(cfgIn[3]);
    assign vActive = W'(cfgIn[4]);
    assign vFront  = W'(cfgIn[5]);
    assign vSync   = W'(cfgIn[6]);
    assign vBack   = W'(cfgIn[7]);

    assign obsVec = {cfgApplied, hSyncPulse, vSyncPulse, dataEnable, lineStart, frameStart, xPos, yPos};

    video_timing_ctrl #(
        .busWidth   (W),
        .hActiveDef (4), .hFrontDef (1), .hSyncDef (2), .hBackDef (1),
        .vActiveDef (3), .vFrontDef (1), .vSyncDef (1), .vBackDef (1)
    ) dut (
        .pixelClk   (pixelClk),
        .reset      (reset),
        .enable     (enable),
        .hActive    (hActive),
        .hFront     (hFront),
        .hSync      (hSync),
        .hBack      (hBack),
        .vActive    (vActive),
        .vFront     (vFront),
        .vSync      (vSync),
        .vBack      (vBack),
        .cfgValid   (cfgValid),
        .cfgApplied (cfgApplied),
        .hSyncPulse (hSyncPulse),
        .vSyncPulse (vSyncPulse),
        .dataEnable (dataEnable),
        .xPos       (xPos),
        .yPos       (yPos),
        .lineStart  (lineStart),
        .frameStart (frameStart)
    );

    always #5 pixelClk = ~pixelClk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int cl(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // 0=active 1=front 2=sync 3=back for a position along one axis
    function automatic int region(input int pos, input int a, input int b, input int c);
        if (pos < cl(a)) return 0;
        if (pos < cl(a) + cl(b)) return 1;
        if (pos < cl(a) + cl(b) + cl(c)) return 2;
        return 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic resetModel();
        act  = '{4, 1, 2, 1, 3, 1, 1, 1};
        pend = act;
        pf   = 1'b0;
        t    = 0;
    endtask

    // Expected outputs after the coming edge, from the pixel index t within the frame
    task automatic modelStep();
        int lineLen, frameLen, col, line, hReg, vReg;
        bit applied, de;
        applied = 1'b0;
        expVec  = '0;
        if (reset) return;
        if (!enable) begin
            t = 0;
            if (cfgValid) begin
                pend = cfgIn;
                pf   = 1'b1;
            end
            return;
        end
        if (t == 0 && pf && !cfgValid) begin
            act     = pend;
            pf      = 1'b0;
            applied = 1'b1;
        end
        if (cfgValid) begin
            pend = cfgIn;
            pf   = 1'b1;
        end
        lineLen  = cl(act[0]) + cl(act[1]) + cl(act[2]) + cl(act[3]);
        frameLen = lineLen * (cl(act[4]) + cl(act[5]) + cl(act[6]) + cl(act[7]));
        col  = t % lineLen;
        line = t / lineLen;
        hReg = region(col, act[0], act[1], act[2]);
        vReg = region(line, act[4], act[5], act[6]);
        de   = (hReg == 0) && (vReg == 0);
        expVec = {applied, hReg == 2, vReg == 2, de, col == 0, t == 0,
                  de ? W'(col) : W'(0), de ? W'(line) : W'(0)};
        t = (t + 1) % frameLen;
    endtask

    task automatic clearMon();
        rel = 0; deCnt = 0; vsCnt = 0; vsFirst = -1; fsCnt = 0; fsLast = 0;
        fsGap = 0; lsLast = 0; lsGap = 0; appCnt = 0; hsPat = '0;
    endtask

    task automatic cycle();
        @(posedge pixelClk);
        modelStep();
        #1;
        check("outputs", obsVec, expVec);
        if (rel < 8) hsPat[rel[2:0]] = hSyncPulse;
        if (rel < 48 && dataEnable) deCnt++;
        if (rel < 48 && vSyncPulse) begin
            if (vsCnt == 0) vsFirst = rel;
            vsCnt++;
        end
        if (frameStart) begin
            if (fsCnt > 0) fsGap = rel - fsLast;
            fsLast = rel;
            fsCnt++;
        end
        if (lineStart) begin
            lsGap  = rel - lsLast;
            lsLast = rel;
        end
        if (cfgApplied) appCnt++;
        rel++;
    endtask

    task automatic runTo(input int target);
        for (int k = 0; k < 1000 && t != target; k++) cycle();
    endtask

    task automatic pulseCfg(input int hAct);
        cfgIn[0] = hAct;
        cfgValid = 1'b1;
        cycle();
        cfgValid = 1'b0;
    endtask

    initial begin
        cfgIn = '{4, 1, 2, 1, 3, 1, 1, 1};
        resetModel();
        clearMon();

        // Reset held, then idle with enable low
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        cycle();

        // Base timing, two frames and a bit
        enable = 1'b1;
        clearMon();
        repeat (100) cycle();
        check("hsyncPattern", hsPat, 64'h60);
        check("deCount", deCnt, 12);
        check("vsyncCount", vsCnt, 8);
        check("vsyncFirst", vsFirst, 32);
        check("frameCount", fsCnt, 3);
        check("framePeriod", fsGap, 48);

        // Mid-frame reconfiguration takes effect at the next frame
        runTo(10);
        pulseCfg(6);
        clearMon();
        runTo(0);
        check("oldLineLen", lsGap, 8);
        check("noEarlyApply", appCnt, 0);
        repeat (31) cycle();
        check("newLineLen", lsGap, 10);
        check("applyOnce", appCnt, 1);

        // Two captures in one frame: only the last applies
        runTo(5);
        pulseCfg(6);
        runTo(20);
        pulseCfg(2);
        clearMon();
        runTo(0);
        repeat (21) cycle();
        check("lastCfgApplyCount", appCnt, 1);
        check("lastCfgLineLen", lsGap, 6);

        // Capture on the frame-end cycle defers one frame and drops the older set
        runTo(3);
        pulseCfg(5);
        runTo(0);
        clearMon();
        pulseCfg(3);
        runTo(0);
        check("deferredNoApply", appCnt, 0);
        check("deferredOldLine", lsGap, 6);
        repeat (21) cycle();
        check("deferredApply", appCnt, 1);
        check("deferredLineLen", lsGap, 7);

        // Dropping enable mid-frame aborts; re-enable restarts the frame
        runTo(20);
        enable = 1'b0;
        cycle();
        check("enableDrop", obsVec, 0);
        repeat (3) cycle();
        enable = 1'b1;
        cycle();
        check("enableRestart", {frameStart, lineStart, dataEnable, xPos, yPos}, {3'b111, 24'd0});
        repeat (30) cycle();

        // Async reset mid-frame with a set pending
        runTo(10);
        pulseCfg(1);
        runTo(20);
        #2;
        reset = 1'b1;
        #1;
        check("resetAsync", obsVec, 0);
        resetModel();
        cycle();
        reset = 1'b0;
        clearMon();
        cycle();
        check("resetRestart", {frameStart, lineStart, dataEnable, xPos, yPos}, {3'b111, 24'd0});
        repeat (30) cycle();
        check("resetDefaults", lsGap, 8);
        check("resetDropsPending", appCnt, 0);

        // Randomized configuration and enable activity
        for (int i = 0; i < 4000; i++) begin
            cfgValid = ($urandom_range(0, 39) == 0);
            if (cfgValid) begin
                for (int f = 0; f < 8; f++) cfgIn[f] = int'($urandom_range(0, 3));
            end
            if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            cycle();
        end
        cfgValid = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 The block SHALL have parameter busWidth, default 12, giving the width of every timing field and position counter.
REQ-002 The block SHALL have parameters hActiveDef/hFrontDef/hSyncDef/hBackDef, defaults 1920/88/44/148, giving the horizontal timing loaded at reset.
REQ-003 The block SHALL have parameters vActiveDef/vFrontDef/vSyncDef/vBackDef, defaults 1080/4/5/36, giving the vertical timing loaded at reset.
REQ-004 The block SHALL have port pixelClk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: run timing when high, idle when low.
REQ-007 The block SHALL have ports hActive, hFront, hSync, hBack, vActive, vFront, vSync, vBack, input, busWidth each: requested timing values.
REQ-008 The block SHALL have port cfgValid, input, 1 bit: a one-cycle strobe that captures all eight timing inputs into the pending set.
REQ-009 The block SHALL have port cfgApplied, output, 1 bit: a one-cycle pulse when the pending set becomes active.
REQ-010 The block SHALL have ports hSyncPulse and vSyncPulse, output, 1 bit each: active-high sync outputs.
REQ-011 The block SHALL have port dataEnable, output, 1 bit: high during the active region.
REQ-012 The block SHALL have ports xPos and yPos, output, busWidth each: active-pixel coordinates, valid only when dataEnable is high.
REQ-013 The block SHALL have ports lineStart and frameStart, output, 1 bit each: one-cycle pulses.

Function
REQ-014 Each axis SHALL run a four-state FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
- Each state lasts its programmed count.
- The horizontal FSM advances per pixelClk.
- The vertical FSM advances once per line, on the horizontal BACK->ACTIVE transition.
REQ-015 hSyncPulse SHALL be high exactly while the horizontal FSM is in SYNC.
REQ-016 vSyncPulse SHALL be high exactly while the vertical FSM is in SYNC, and SHALL change only on line boundaries.
REQ-017 dataEnable SHALL be high only when both FSMs are in ACTIVE.
- xPos runs 0..hActive-1 and yPos runs 0..vActive-1.
- xPos and yPos SHALL be held at 0 when dataEnable is low.
REQ-018 All outputs SHALL be registered, and xPos/yPos SHALL be cycle-aligned with dataEnable (zero relative latency).
REQ-019 lineStart SHALL pulse on the first cycle of every horizontal ACTIVE, in every line including blanking lines.
REQ-020 frameStart SHALL pulse on the first cycle of horizontal ACTIVE when the vertical FSM enters ACTIVE with yPos=0.
REQ-021 Line period SHALL be hActive+hFront+hSync+hBack cycles, and frame period SHALL be the line period times (vActive+vFront+vSync+vBack).
REQ-022 Phase counters SHALL compare against (value-1) and wrap to 0 on transition, with no overflow past busWidth.
REQ-023 A programmed field value of 0 SHALL be treated as 1.
REQ-024 cfgValid SHALL capture inputs into pending registers and set a pending flag.
- A second cfgValid before application SHALL overwrite the pending set; only the last set is applied.
REQ-025 The pending set SHALL become active only at frame end (vertical BACK->ACTIVE transition), never mid-frame.
- On that same cycle the pending flag SHALL clear and cfgApplied SHALL pulse.
REQ-026 When cfgValid coincides with the frame-end cycle, the new values SHALL stay pending for the next frame end, and the previously pending set (if any) SHALL be discarded.
REQ-027 While enable is low, both FSMs SHALL hold at ACTIVE with counters 0, and all sync, DE, position and strobe outputs SHALL be 0.
- Config capture SHALL continue while enable is low.
- A pending set SHALL be applied on the first cycle enable is high.
REQ-028 On enable rising, the first cycle SHALL be x=0,y=0, with frameStart, lineStart and dataEnable all high.
REQ-029 Deasserting enable mid-frame SHALL abort the frame; the next enable restarts from x=0,y=0.

Reset
REQ-030 On reset assertion, asynchronously:
- active and pending timing SHALL load the parameter defaults;
- the pending flag SHALL clear;
- FSMs SHALL go to ACTIVE with counters 0;
- all outputs SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame and any pending set, and the first enabled cycle after release SHALL behave as REQ-028.

Structure
REQ-032 Package video_timing_pkg SHALL hold:
- the phase state encoding (ACTIVE=2'd0, FRONT=2'd1, SYNC=2'd2, BACK=2'd3);
- the default 1080p timing constants.
REQ-033 A sub-module timing_phase_fsm SHALL be instantiated twice, horizontal and vertical.
- Inputs: step, four lengths, clear.
- Outputs: state, position counter, wrap strobe.

Verification
REQ-034 Test config H=4/1/2/1, V=3/1/1/1 with enable held high: the line SHALL be 8 cycles with hSyncPulse high on cycles 5-6, and the frame SHALL be 48 cycles with 12 dataEnable cycles (x 0..3, y 0..2).
REQ-035 With the REQ-034 config, vSyncPulse SHALL be high for exactly 8 cycles starting on line 4, and frameStart SHALL occur every 48 cycles.
REQ-036 A cfgValid mid-frame changing hActive to 6 SHALL leave the current frame at 8-cycle lines; the next frame SHALL have 10-cycle lines, with cfgApplied pulsing once at the boundary.
REQ-037 Two cfgValid pulses in one frame (hActive 6, then 2) SHALL result only in hActive=2 being applied.
REQ-038 A cfgValid on the frame-end cycle SHALL be applied one frame later.
REQ-039 Asserting reset or dropping enable at cycle 20 SHALL drive all outputs to 0 immediately; the next enabled cycle SHALL give frameStart=1, xPos=0, yPos=0.
